// File: rtl/vector_offload_queue.sv
// -----------------------------------------------------------------------------
// vector_offload_queue
//
// Buffered offload front-end between the core APU port and the vector
// accelerator backend. Granted requests enter a DEPTH-entry in-order
// instruction queue. Each instruction issued to the backend leaves its
// offload ID in an in-order tag FIFO. A completion pops the oldest tag, and
// the result is returned to the core one cycle later with that ID.
//
// Optional feature macro: VOQ_BYPASS_EN
//   When defined, a request granted while the queue is empty, the tag FIFO
//   is not full and the backend is ready issues in the same cycle. The
//   instruction is never written into the queue.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   apu_req / apu_gnt     core offload request / same-cycle grant
//   apu_operands_i, apu_op, apu_flags_i, offloaded_id_i
//                         instruction payload captured on grant
//   issue_valid_o / issue_ready_i
//                         head instruction toward backend (valid/ready)
//   issue_operands_o, issue_op_o, issue_flags_o, issue_id_o
//                         head instruction payload (zero when not valid)
//   done_valid_i, done_result_i
//                         backend completion of the oldest issued instruction
//   apu_rvalid, apu_result, instruction_id
//                         one-cycle result pulse to the core
//   flush_i               drop every unissued entry
//   core_halt_o           instruction queue full
//   occupancy_o           unissued entries held
//   err_o                 sticky: completion seen with no outstanding tag
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. While valid is high and ready is low, the payload holds steady.
// -----------------------------------------------------------------------------
module vector_offload_queue #(
   parameter int DEPTH        = 4,
   parameter int X_ID_WIDTH   = 4,
   parameter int NUM_OPERANDS = 3,
   parameter int OP_WIDTH     = 6,
   parameter int FLAGS_WIDTH  = 15
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         apu_req,
   output logic                         apu_gnt,
   input  logic [NUM_OPERANDS*32-1:0]   apu_operands_i,
   input  logic [OP_WIDTH-1:0]          apu_op,
   input  logic [FLAGS_WIDTH-1:0]       apu_flags_i,
   input  logic [X_ID_WIDTH-1:0]        offloaded_id_i,
   output logic                         issue_valid_o,
   input  logic                         issue_ready_i,
   output logic [NUM_OPERANDS*32-1:0]   issue_operands_o,
   output logic [OP_WIDTH-1:0]          issue_op_o,
   output logic [FLAGS_WIDTH-1:0]       issue_flags_o,
   output logic [X_ID_WIDTH-1:0]        issue_id_o,
   input  logic                         done_valid_i,
   input  logic [31:0]                  done_result_i,
   output logic                         apu_rvalid,
   output logic [31:0]                  apu_result,
   output logic [X_ID_WIDTH-1:0]        instruction_id,
   input  logic                         flush_i,
   output logic                         core_halt_o,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
   output logic                         err_o
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(DEPTH+1);
   localparam int ENTRY_W = NUM_OPERANDS*32 + OP_WIDTH + FLAGS_WIDTH + X_ID_WIDTH;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Instruction queue storage and state
   logic [ENTRY_W-1:0]    q_mem [DEPTH];
   logic [PTR_W-1:0]      q_rptr_q, q_rptr_d;
   logic [PTR_W-1:0]      q_wptr_q, q_wptr_d;
   logic [CNT_W-1:0]      q_cnt_q,  q_cnt_d;

   // Tag FIFO storage and state
   logic [X_ID_WIDTH-1:0] tag_mem [DEPTH];
   logic [PTR_W-1:0]      tag_rptr_q, tag_rptr_d;
   logic [PTR_W-1:0]      tag_wptr_q, tag_wptr_d;
   logic [CNT_W-1:0]      tag_cnt_q,  tag_cnt_d;

   // Result return registers
   logic                  rvalid_q;
   logic [31:0]           result_q;
   logic [X_ID_WIDTH-1:0] rid_q;
   logic                  err_q;

   logic                  q_full, q_empty, tag_full, tag_empty;
   logic                  bypass, issue_fire;
   logic                  q_push, q_pop, tag_push, tag_pop;
   logic [ENTRY_W-1:0]    entry_in, head_entry, issue_entry;

   assign q_full    = (q_cnt_q == FULL_CNT);
   assign q_empty   = (q_cnt_q == '0);
   assign tag_full  = (tag_cnt_q == FULL_CNT);
   assign tag_empty = (tag_cnt_q == '0);

   assign entry_in   = {apu_operands_i, apu_op, apu_flags_i, offloaded_id_i};
   assign head_entry = q_mem[q_rptr_q];

   // Grant depends only on registered fullness, so a pop in the same cycle
   // does not open a slot for the push.
   assign apu_gnt = apu_req & ~q_full & ~flush_i & ~reset;

`ifdef VOQ_BYPASS_EN
   assign bypass = apu_gnt & q_empty & ~tag_full & issue_ready_i;
`else
   assign bypass = 1'b0;
`endif

   assign issue_valid_o = (~q_empty | bypass) & ~tag_full & ~flush_i & ~reset;
   assign issue_fire    = issue_valid_o & issue_ready_i;

   // A bypassed instruction skips the queue entirely.
   assign q_push   = apu_gnt & ~bypass;
   assign q_pop    = issue_fire & ~bypass;
   assign tag_push = issue_fire;
   assign tag_pop  = done_valid_i & ~tag_empty;

   // Payload is forced to zero while nothing is offered.
   always_comb begin
      issue_entry = '0;
      if (bypass) begin
         issue_entry = entry_in;
      end else if (issue_valid_o) begin
         issue_entry = head_entry;
      end
   end

   assign {issue_operands_o, issue_op_o, issue_flags_o, issue_id_o} = issue_entry;

   // Next-state for both FIFOs
   always_comb begin
      q_rptr_d   = q_rptr_q;
      q_wptr_d   = q_wptr_q;
      q_cnt_d    = q_cnt_q;
      tag_rptr_d = tag_rptr_q;
      tag_wptr_d = tag_wptr_q;
      tag_cnt_d  = tag_cnt_q;

      if (flush_i) begin
         // Push and pop are both blocked while flushing. Collapse the queue
         // onto the read pointer.
         q_wptr_d = q_rptr_q;
         q_cnt_d  = '0;
      end else begin
         if (q_push) q_wptr_d = q_wptr_q + 1'b1;
         if (q_pop)  q_rptr_d = q_rptr_q + 1'b1;
         q_cnt_d = q_cnt_q + CNT_W'(q_push) - CNT_W'(q_pop);
      end

      // The tag FIFO is unaffected by flush. Outstanding results still return.
      if (tag_push) tag_wptr_d = tag_wptr_q + 1'b1;
      if (tag_pop)  tag_rptr_d = tag_rptr_q + 1'b1;
      tag_cnt_d = tag_cnt_q + CNT_W'(tag_push) - CNT_W'(tag_pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_rptr_q   <= '0;
         q_wptr_q   <= '0;
         q_cnt_q    <= '0;
         tag_rptr_q <= '0;
         tag_wptr_q <= '0;
         tag_cnt_q  <= '0;
         rvalid_q   <= 1'b0;
         result_q   <= '0;
         rid_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         q_rptr_q   <= q_rptr_d;
         q_wptr_q   <= q_wptr_d;
         q_cnt_q    <= q_cnt_d;
         tag_rptr_q <= tag_rptr_d;
         tag_wptr_q <= tag_wptr_d;
         tag_cnt_q  <= tag_cnt_d;
         rvalid_q   <= tag_pop;
         if (tag_pop) begin
            result_q <= done_result_i;
            rid_q    <= tag_mem[tag_rptr_q];
         end
         if (done_valid_i && tag_empty) begin
            err_q <= 1'b1;
         end
      end
   end

   // The storage arrays need no reset. Pointers and counts define which
   // entries are live, and outputs are masked when nothing is valid.
   always_ff @(posedge clk) begin
      if (q_push) begin
         q_mem[q_wptr_q] <= entry_in;
      end
      if (tag_push) begin
         tag_mem[tag_wptr_q] <= issue_id_o;
      end
   end

   assign apu_rvalid     = rvalid_q;
   assign apu_result     = result_q;
   assign instruction_id = rid_q;
   assign err_o          = err_q;
   assign core_halt_o    = q_full;
   assign occupancy_o    = q_cnt_q;

endmodule

// File: tb/tb_vector_offload_queue.sv
// -----------------------------------------------------------------------------
// tb_vector_offload_queue
//
// Directed bench for vector_offload_queue. Issued payloads and returned
// results are checked against expected queues filled when stimulus is driven.
// -----------------------------------------------------------------------------
module tb_vector_offload_queue;

   localparam int DEPTH   = 4;
   localparam int IDW     = 4;
   localparam int NOPS    = 3;
   localparam int OPW     = 6;
   localparam int FLW     = 15;
   localparam int CNTW    = $clog2(DEPTH+1);
   localparam int ENTRY_W = NOPS*32 + OPW + FLW + IDW;
   localparam int RV_W    = 32 + IDW;

   logic                 clk;
   logic                 reset;
   logic                 apu_req;
   logic                 apu_gnt;
   logic [NOPS*32-1:0]   apu_operands_i;
   logic [OPW-1:0]       apu_op;
   logic [FLW-1:0]       apu_flags_i;
   logic [IDW-1:0]       offloaded_id_i;
   logic                 issue_valid_o;
   logic                 issue_ready_i;
   logic [NOPS*32-1:0]   issue_operands_o;
   logic [OPW-1:0]       issue_op_o;
   logic [FLW-1:0]       issue_flags_o;
   logic [IDW-1:0]       issue_id_o;
   logic                 done_valid_i;
   logic [31:0]          done_result_i;
   logic                 apu_rvalid;
   logic [31:0]          apu_result;
   logic [IDW-1:0]       instruction_id;
   logic                 flush_i;
   logic                 core_halt_o;
   logic [CNTW-1:0]      occupancy_o;
   logic                 err_o;

   logic [ENTRY_W-1:0]   exp_q[$];
   logic [RV_W-1:0]      rv_q[$];
   logic [ENTRY_W-1:0]   mon_entry;
   logic [RV_W-1:0]      mon_rv;
   int                   checks = 0;
   int                   errors = 0;

   vector_offload_queue #(
      .DEPTH(DEPTH), .X_ID_WIDTH(IDW), .NUM_OPERANDS(NOPS),
      .OP_WIDTH(OPW), .FLAGS_WIDTH(FLW)
   ) dut (
      .clk(clk), .reset(reset),
      .apu_req(apu_req), .apu_gnt(apu_gnt),
      .apu_operands_i(apu_operands_i), .apu_op(apu_op),
      .apu_flags_i(apu_flags_i), .offloaded_id_i(offloaded_id_i),
      .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
      .issue_operands_o(issue_operands_o), .issue_op_o(issue_op_o),
      .issue_flags_o(issue_flags_o), .issue_id_o(issue_id_o),
      .done_valid_i(done_valid_i), .done_result_i(done_result_i),
      .apu_rvalid(apu_rvalid), .apu_result(apu_result),
      .instruction_id(instruction_id), .flush_i(flush_i),
      .core_halt_o(core_halt_o), .occupancy_o(occupancy_o), .err_o(err_o)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Driver: one granted request with random payload
   task automatic push(input logic [IDW-1:0] id);
      apu_req        = 1'b1;
      offloaded_id_i = id;
      apu_operands_i = {$urandom(), $urandom(), $urandom()};
      apu_op         = OPW'($urandom());
      apu_flags_i    = FLW'($urandom());
      #1;
      check("push_gnt", apu_gnt, 1'b1);
      exp_q.push_back({apu_operands_i, apu_op, apu_flags_i, id});
      tick();
      apu_req = 1'b0;
   endtask

   // Driver: one completion for the oldest outstanding ID
   task automatic done(input logic [31:0] r, input logic [IDW-1:0] id);
      done_valid_i  = 1'b1;
      done_result_i = r;
      rv_q.push_back({r, id});
      tick();
      done_valid_i = 1'b0;
   endtask

   // Scoreboard monitor, sampled away from the rising edge
   always @(negedge clk) begin
      if (!reset) begin
         if (issue_valid_o && issue_ready_i) begin
            check("issue_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               mon_entry = exp_q.pop_front();
               check("issue_entry", {issue_operands_o, issue_op_o, issue_flags_o, issue_id_o}, mon_entry);
            end
         end
         if (apu_rvalid) begin
            check("rvalid_expected", rv_q.size() > 0, 1'b1);
            if (rv_q.size() > 0) begin
               mon_rv = rv_q.pop_front();
               check("result", {apu_result, instruction_id}, mon_rv);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; apu_req = 1'b0; apu_operands_i = '0; apu_op = '0;
      apu_flags_i = '0; offloaded_id_i = '0; issue_ready_i = 1'b0;
      done_valid_i = 1'b0; done_result_i = '0; flush_i = 1'b0;
      tick();
      tick();
      // Reset values
      check("rst_gnt", apu_gnt, 1'b0);
      check("rst_issue_valid", issue_valid_o, 1'b0);
      check("rst_issue_id", issue_id_o, '0);
      check("rst_issue_ops", issue_operands_o, '0);
      check("rst_rvalid", apu_rvalid, 1'b0);
      check("rst_result", apu_result, '0);
      check("rst_halt", core_halt_o, 1'b0);
      check("rst_occ", occupancy_o, '0);
      check("rst_err", err_o, 1'b0);
      reset = 1'b0;
      tick();

      // Fill the queue with the backend stalled
      push(4'd1); push(4'd2); push(4'd3);
      check("occ3", occupancy_o, 3'd3);
      check("halt_at3", core_halt_o, 1'b0);
      check("head_valid_stall", issue_valid_o, 1'b1);
      check("head_id_stall", issue_id_o, 4'd1);
      push(4'd4);
      check("occ4", occupancy_o, 3'd4);
      check("halt_at4", core_halt_o, 1'b1);
      check("head_id_stable", issue_id_o, 4'd1);

      // Full: no grant, even with a pop in the same cycle
      apu_req = 1'b1; offloaded_id_i = 4'd5;
      apu_operands_i = {$urandom(), $urandom(), $urandom()};
      apu_op = OPW'($urandom()); apu_flags_i = FLW'($urandom());
      #1;
      check("full_gnt", apu_gnt, 1'b0);
      issue_ready_i = 1'b1;
      #1;
      check("full_pop_gnt", apu_gnt, 1'b0);
      tick();
      issue_ready_i = 1'b0;
      #1;
      check("after_pop_gnt", apu_gnt, 1'b1);
      exp_q.push_back({apu_operands_i, apu_op, apu_flags_i, 4'd5});
      tick();
      apu_req = 1'b0;
      check("occ_refill", occupancy_o, 3'd4);

      // Drain until the tag FIFO fills (IDs 1..4 outstanding)
      issue_ready_i = 1'b1;
      tick(); tick(); tick();
      check("tag_full_blocks", issue_valid_o, 1'b0);
      check("occ_tagfull", occupancy_o, 3'd1);
      issue_ready_i = 1'b0;

      // Back-to-back completions for IDs 1..4
      for (int i = 1; i <= 4; i++) begin
         done($urandom(), IDW'(i));
         check("b2b_rvalid", apu_rvalid, 1'b1);
      end

      // Issue 5 and 6, then complete them with fixed results
      push(4'd6);
      issue_ready_i = 1'b1;
      tick(); tick();
      issue_ready_i = 1'b0;
      check("occ_drained", occupancy_o, 3'd0);
      check("empty_no_valid", issue_valid_o, 1'b0);
      done(32'hA5, 4'd5);
      check("rv_a5_valid", apu_rvalid, 1'b1);
      check("rv_a5", {apu_result, instruction_id}, {32'hA5, 4'd5});
      done(32'h3C, 4'd6);
      check("rv_3c_valid", apu_rvalid, 1'b1);
      check("rv_3c", {apu_result, instruction_id}, {32'h3C, 4'd6});
      tick();
      check("rv_pulse_end", apu_rvalid, 1'b0);

      // Flush with 3 unissued entries and 1 outstanding tag
      push(4'd8);
      issue_ready_i = 1'b1;
      tick();
      issue_ready_i = 1'b0;
      push(4'd9); push(4'd10); push(4'd11);
      check("occ_preflush", occupancy_o, 3'd3);
      flush_i = 1'b1; apu_req = 1'b1; offloaded_id_i = 4'd15;
      #1;
      check("flush_gnt", apu_gnt, 1'b0);
      check("flush_no_valid", issue_valid_o, 1'b0);
      tick();
      flush_i = 1'b0; apu_req = 1'b0;
      exp_q.delete();
      check("occ_postflush", occupancy_o, 3'd0);
      check("postflush_valid", issue_valid_o, 1'b0);
      done($urandom(), 4'd8);
      check("flush_rv_id", instruction_id, 4'd8);
      // Queue keeps working after the flush
      push(4'd12);
      issue_ready_i = 1'b1;
      tick();
      issue_ready_i = 1'b0;
      done($urandom(), 4'd12);
      tick();

      // Completion with no outstanding tag
      done_valid_i = 1'b1; done_result_i = 32'h77;
      tick();
      done_valid_i = 1'b0;
      check("orphan_no_rvalid", apu_rvalid, 1'b0);
      check("orphan_err", err_o, 1'b1);
      tick(); tick();
      check("err_sticky", err_o, 1'b1);

      // Reset mid-operation drops queued and outstanding entries
      push(4'd13); push(4'd14);
      issue_ready_i = 1'b1;
      tick();
      issue_ready_i = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      check("midrst_occ", occupancy_o, 3'd0);
      check("midrst_valid", issue_valid_o, 1'b0);
      check("midrst_err", err_o, 1'b0);
      done_valid_i = 1'b1; done_result_i = 32'h55;
      tick();
      done_valid_i = 1'b0;
      check("midrst_no_rvalid", apu_rvalid, 1'b0);
      check("midrst_err_set", err_o, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      check("err_cleared", err_o, 1'b0);

      // Grant-to-issue latency on an empty queue
      issue_ready_i = 1'b1;
      apu_req = 1'b1; offloaded_id_i = 4'd7;
      apu_operands_i = {$urandom(), $urandom(), $urandom()};
      apu_op = OPW'($urandom()); apu_flags_i = FLW'($urandom());
      #1;
      check("lat_gnt", apu_gnt, 1'b1);
      exp_q.push_back({apu_operands_i, apu_op, apu_flags_i, 4'd7});
`ifdef VOQ_BYPASS_EN
      check("bypass_valid", issue_valid_o, 1'b1);
      check("bypass_id", issue_id_o, 4'd7);
      tick();
      apu_req = 1'b0;
      check("bypass_occ", occupancy_o, 3'd0);
      check("bypass_after_valid", issue_valid_o, 1'b0);
`else
      check("nobypass_valid", issue_valid_o, 1'b0);
      tick();
      apu_req = 1'b0;
      check("nobypass_valid_next", issue_valid_o, 1'b1);
      check("nobypass_id_next", issue_id_o, 4'd7);
      check("nobypass_occ", occupancy_o, 3'd1);
      tick();
      check("nobypass_drained", occupancy_o, 3'd0);
`endif
      issue_ready_i = 1'b0;
      done($urandom(), 4'd7);
      tick();

      // Nothing left unmatched
      check("issue_q_empty", exp_q.size(), 0);
      check("rv_q_empty", rv_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
